// File: rtl/fifo_out_lvl.sv
// fifo_out_lvl: first-word-fall-through AXI-Stream FIFO with level reporting.
//
// Parameters
//   OUTW      data width in bits (>= 1)
//   DEPTH     number of entries (>= 2, any value, not only powers of two)
//   AF_THRESH almost-full level (1..DEPTH)
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-high reset
//   flush           synchronous clear of all stored entries
//   IN_AXIS_*       write side (TDATA, TLAST, TVALID in; TREADY out)
//   OUT_AXIS_*      read side (TDATA, TLAST, TVALID out; TREADY in)
//   count           number of stored entries
//   almost_full     count >= AF_THRESH
//   overflow_err    sticky: a write was attempted while full (reset clears it)
module fifo_out_lvl #(
    parameter int  OUTW      = 24,
    parameter int  DEPTH     = 19,
    parameter int  AF_THRESH = DEPTH - 2,
    localparam int CNTW      = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [OUTW-1:0] IN_AXIS_TDATA,
    input  logic            IN_AXIS_TLAST,
    input  logic            IN_AXIS_TVALID,
    output logic            IN_AXIS_TREADY,
    output logic [OUTW-1:0] OUT_AXIS_TDATA,
    output logic            OUT_AXIS_TLAST,
    output logic            OUT_AXIS_TVALID,
    input  logic            OUT_AXIS_TREADY,
    output logic [CNTW-1:0] count,
    output logic            almost_full,
    output logic            overflow_err
);

    localparam int PTRW = $clog2(DEPTH);

    // Each entry holds {TLAST, TDATA}.
    logic [OUTW:0]     mem [DEPTH];
    logic [PTRW-1:0]   wr_ptr_reg;
    logic [PTRW-1:0]   rd_ptr_reg;
    logic [CNTW-1:0]   count_reg;
    logic              overflow_reg;
    logic [CNTW-1:0]   count_next;
    logic              wr_en;
    logic              rd_en;
    logic              full;

    // Explicit wrap so a non-power-of-two depth never aliases.
    function automatic logic [PTRW-1:0] bump(input logic [PTRW-1:0] p);
        if (p == PTRW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full            = (count_reg == CNTW'(DEPTH));
    // Ready depends only on the stored level, never on the consumer side.
    assign IN_AXIS_TREADY  = !full && !flush;
    assign OUT_AXIS_TVALID = (count_reg != '0);
    assign wr_en           = IN_AXIS_TVALID && IN_AXIS_TREADY;
    // A read coinciding with flush is discarded along with everything else.
    assign rd_en           = OUT_AXIS_TVALID && OUT_AXIS_TREADY && !flush;

    // Zero-latency head: the entry at rd_ptr is driven straight out.
    assign {OUT_AXIS_TLAST, OUT_AXIS_TDATA} = mem[rd_ptr_reg];

    assign count        = count_reg;
    assign almost_full  = (count_reg >= CNTW'(AF_THRESH));
    assign overflow_err = overflow_reg;

    always_comb begin
        count_next = count_reg;
        if (wr_en && !rd_en) begin
            count_next = count_reg + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage is not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {IN_AXIS_TLAST, IN_AXIS_TDATA};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            // Overflow is sticky and deliberately survives flush.
            if (IN_AXIS_TVALID && full) begin
                overflow_reg <= 1'b1;
            end
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_reg <= bump(wr_ptr_reg);
                end
                if (rd_en) begin
                    rd_ptr_reg <= bump(rd_ptr_reg);
                end
                count_reg <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_fifo_out_lvl.sv
// Directed testbench for fifo_out_lvl (OUTW=24, DEPTH=5, AF_THRESH=4).
// Stimulus pushes each accepted word into a scoreboard queue; an independent
// monitor pops and compares every word the DUT hands out.
module tb_fifo_out_lvl;

    localparam int OUTW  = 24;
    localparam int DEPTH = 5;
    localparam int AFT   = 4;
    localparam int CNTW  = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [OUTW-1:0] in_data;
    logic            in_last;
    logic            in_valid;
    logic            in_ready;
    logic [OUTW-1:0] out_data;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic [CNTW-1:0] count;
    logic            almost_full;
    logic            overflow_err;

    int vectors    = 0;
    int miscompares = 0;

    logic [OUTW:0] sb_q [$];

    fifo_out_lvl #(.OUTW(OUTW), .DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .IN_AXIS_TDATA   (in_data),
        .IN_AXIS_TLAST   (in_last),
        .IN_AXIS_TVALID  (in_valid),
        .IN_AXIS_TREADY  (in_ready),
        .OUT_AXIS_TDATA  (out_data),
        .OUT_AXIS_TLAST  (out_last),
        .OUT_AXIS_TVALID (out_valid),
        .OUT_AXIS_TREADY (out_ready),
        .count           (count),
        .almost_full     (almost_full),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: inputs are stable mid-cycle, so a handshake seen on the
    // falling edge is the read that the next rising edge will perform.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_word: got 0x%0h with nothing expected", {out_last, out_data});
            end else begin
                logic [OUTW:0] exp_w;
                exp_w = sb_q.pop_front();
                if ({out_last, out_data} !== exp_w) begin
                    miscompares++;
                    $display("FAIL out_word: got last=%0b data=0x%06h, expected last=%0b data=0x%06h",
                             out_last, out_data, exp_w[OUTW], exp_w[OUTW-1:0]);
                end else begin
                    $display("ok   out_word: last=%0b data=0x%06h", out_last, out_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for a cycle; exp_rdy is the hand-derived readiness.
    task automatic put(input logic [OUTW-1:0] d, input logic l, input logic exp_rdy);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (exp_rdy && !flush) begin
            sb_q.push_back({l, d});
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_data = '0; in_last = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_almost_full", {31'd0, almost_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Fill then drain.
        for (int i = 1; i <= 5; i++) begin
            put(OUTW'(i), 1'b0, 1'b1);
            check("fill_count", {29'd0, count}, 32'(i));
            check("fill_af", {31'd0, almost_full}, (i >= 4) ? 32'd1 : 32'd0);
        end
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("drain_count", {29'd0, count}, 32'd0);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Streaming wrap-around.
        for (int i = 0; i < 12; i++) begin
            put(OUTW'(24'h000100 + i), 1'b0, 1'b1);
            check("stream_count", {29'd0, count}, 32'd1);
        end
        tick();
        check("stream_end_count", {29'd0, count}, 32'd0);

        // Read and attempted write while full.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) put(OUTW'(24'h000200 + i), 1'b0, 1'b1);
        out_ready = 1'b1;
        put(24'h0002FF, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("full_rw_count", {29'd0, count}, 32'd4);
        check("full_rw_in_ready", {31'd0, in_ready}, 32'd1);
        check("full_rw_overflow", {31'd0, overflow_err}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("full_rw_drained", {29'd0, count}, 32'd0);

        // TLAST travels with its word.
        out_ready = 1'b0;
        put(24'h000301, 1'b0, 1'b1);
        put(24'h000302, 1'b0, 1'b1);
        put(24'h000303, 1'b1, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;

        // Flush with a concurrent write.
        for (int i = 1; i <= 3; i++) put(OUTW'(24'h000400 + i), 1'b0, 1'b1);
        check("pre_flush_count", {29'd0, count}, 32'd3);
        flush = 1'b1;
        sb_q.delete();
        put(24'h0004FF, 1'b0, 1'b0);
        flush = 1'b0;
        check("flush_count", {29'd0, count}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_overflow", {31'd0, overflow_err}, 32'd1);
        put(24'h000405, 1'b1, 1'b1);
        check("post_flush_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset between edges.
        put(24'h000501, 1'b0, 1'b1);
        put(24'h000502, 1'b0, 1'b1);
        check("pre_reset_count", {29'd0, count}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        sb_q.delete();
        check("async_rst_count", {29'd0, count}, 32'd0);
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_overflow", {31'd0, overflow_err}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #1;
        reset = 1'b0;
        tick();
        put(24'h000601, 1'b0, 1'b1);
        check("after_rst_count", {29'd0, count}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_out_lvl.md
FIFO_OUT_LVL -- requirements
Module: fifo_out_lvl

Interface
REQ-001 SHALL have parameter OUTW, default 24: data width in bits, legal range 1 or more.
REQ-002 SHALL have parameter DEPTH, default 19: entry count, legal range 2 or more, need not be a power of 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2: almost-full level, legal range 1..DEPTH.
REQ-004 SHALL have derived localparam CNTW = $clog2(DEPTH+1): width of the count port.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1 bit: synchronous clear of all stored entries.
REQ-008 SHALL have port IN_AXIS_TDATA, input, OUTW bits: write data.
REQ-009 SHALL have port IN_AXIS_TLAST, input, 1 bit: end-of-frame marker, stored with its data word.
REQ-010 SHALL have port IN_AXIS_TVALID, input, 1 bit: write data is valid.
REQ-011 SHALL have port IN_AXIS_TREADY, output, 1 bit: FIFO can accept a word.
REQ-012 SHALL have port OUT_AXIS_TDATA, output, OUTW bits: head-of-FIFO data.
REQ-013 SHALL have port OUT_AXIS_TLAST, output, 1 bit: TLAST stored with the head word.
REQ-014 SHALL have port OUT_AXIS_TVALID, output, 1 bit: head word is valid.
REQ-015 SHALL have port OUT_AXIS_TREADY, input, 1 bit: consumer accepts the head word.
REQ-016 SHALL have port count, output, CNTW bits: number of stored entries.
REQ-017 SHALL have port almost_full, output, 1 bit: asserted when count >= AF_THRESH.
REQ-018 SHALL have port overflow_err, output, 1 bit: sticky flag, set by a write attempt while full.

Function
REQ-019 SHALL define a write as IN_AXIS_TVALID && IN_AXIS_TREADY, and a read as OUT_AXIS_TVALID && OUT_AXIS_TREADY.
REQ-020 SHALL drive IN_AXIS_TREADY = (count != DEPTH) && !flush, with no combinational path from OUT_AXIS_TREADY.
REQ-021 SHALL drive OUT_AXIS_TVALID = (count != 0) with first-word-fall-through.
REQ-022 SHALL make OUT_AXIS_TDATA and OUT_AXIS_TLAST present the head entry in the same cycle that OUT_AXIS_TVALID is high, with zero read latency.
REQ-023 SHALL, on a write, store {TLAST, TDATA} at wr_ptr and advance wr_ptr.
REQ-024 SHALL, on a read, advance rd_ptr.
REQ-025 SHALL advance wr_ptr and rd_ptr modulo DEPTH: value DEPTH-1 wraps to 0.
REQ-026 SHALL update count as +1 on a write only, -1 on a read only, and unchanged on simultaneous read and write.
REQ-027 SHALL allow simultaneous read and write at any count from 1 to DEPTH-1, sustaining 1 word/cycle.
REQ-028 SHALL, when empty, present a written word on the output in the next cycle; there is no same-cycle bypass.
REQ-029 SHALL, when full, block writes via TREADY=0; a read in that cycle frees one slot for the following cycle.
REQ-030 SHALL, when flush=1 at a clock edge, set wr_ptr, rd_ptr and count to 0, ignoring any read or write in that cycle; storage contents need not be cleared.
REQ-031 SHALL set overflow_err at the edge where IN_AXIS_TVALID=1 and count==DEPTH; it is cleared only by reset, not by flush.
REQ-032 SHALL keep the contents of a held word stable while OUT_AXIS_TVALID=1 and OUT_AXIS_TREADY=0 (AXI-Stream rule).
REQ-033 SHALL allow DEPTH that is not a power of 2 without aliasing, with pointers of width $clog2(DEPTH).

Reset
REQ-034 SHALL, while reset=1 (asynchronous, active-high), force wr_ptr=0, rd_ptr=0, count=0 and overflow_err=0.
REQ-035 SHALL hold these outputs during reset: IN_AXIS_TREADY=1 and OUT_AXIS_TVALID=0; almost_full=0; OUT_AXIS_TDATA is don't-care.
REQ-036 SHALL discard all contents when reset is asserted mid-operation; the first word written after reset release appears as the head.

Verification (OUTW=24, DEPTH=5, AF_THRESH=4)
REQ-037 SHALL cover fill then drain: write 0x000001..0x000005 with OUT_AXIS_TREADY=0 -> count 1,2,3,4,5; almost_full rises with count=4; TREADY=0 at count=5; then read with TREADY=1 -> data 1..5 in order, and TVALID falls after the 5th read.
REQ-038 SHALL cover wrap-around: 12 words streamed with TVALID=TREADY=1 on both sides -> 12 outputs in order, count stays 1 in steady state, and the pointers wrap twice.
REQ-039 SHALL cover simultaneous read and write at full: count=5, IN_TVALID=1, OUT_TREADY=1 -> no write that cycle, count becomes 4, TREADY=1 the next cycle, and overflow_err=1.
REQ-040 SHALL cover TLAST: write 3 words with TLAST=0,0,1 -> OUT_AXIS_TLAST=1 only on the 3rd output word.
REQ-041 SHALL cover flush: count=3, then flush=1 with a concurrent write -> next cycle count=0, TVALID=0, and the concurrent word is dropped; overflow_err is unchanged.
REQ-042 SHALL cover asynchronous reset mid-stream: reset asserted between clock edges at count=2 -> count=0, TVALID=0 and overflow_err=0 immediately, before the next edge.
